item_count_bank: RTL
====================

// Module: item_count_bank
// PURPOSE
//  Storage and write side of the per-item inventory counts. Holds 8 item counts,
//  each WIDTH bits wide, and drives them on W0..W7, which feed the 8:1 count-select mux.
//  Each vend request checks the selected slot, decrements its count and times the
//  dispense pulse. A restock request adds to the selected slot's count.
// PARAMETERS
//  WIDTH        4   bit width of each item count
//  INIT_COUNT   5   value loaded into every slot on reset
//  MAX_COUNT    15  saturation ceiling for restock (must be <= 2**WIDTH-1)
//  DISP_CYCLES  4   number of cycles Dispense is held high per successful vend
// PORTS
//  Clock       in   1      system clock; all state updates on the rising edge
//  Reset       in   1      synchronous, active-high reset
//  S2,S1,S0    in   1 each item select; {S2,S1,S0} is the slot index 0..7
//  Vend        in   1      vend request; sampled only in IDLE
//  Restock     in   1      restock request; sampled only in IDLE
//  RestockVal  in   WIDTH  amount added to the selected slot on Restock
//  W0..W7      out  WIDTH  current count of slots 0..7 (registered)
//  Dispense    out  1      high while the motor is driven for the latched slot
//  Done        out  1      1-cycle pulse when a successful vend completes
//  SoldOut     out  1      1-cycle pulse when a vend hits a slot with count 0
//  Busy        out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset (synchronous): every slot is set to INIT_COUNT and the FSM goes to IDLE.
//    Dispense, Done, SoldOut and Busy are 0. Reset takes effect mid-vend:
//    the operation is aborted and no further decrement occurs.
//  - FSM states: IDLE, CHECK, DISPENSE, DONE, SOLDOUT. All outputs are registered.
//  - IDLE:
//    - Vend=1: latch {S2,S1,S0} into sel_q and go to CHECK.
//    - Vend=0, Restock=1: slot[{S2,S1,S0}] <= min(slot + RestockVal, MAX_COUNT).
//      The sum uses WIDTH+1 bits, so it never wraps. Completes in one cycle; stay in IDLE.
//    - Vend=1 and Restock=1 together: Vend wins and Restock is dropped.
//  - CHECK (1 cycle):
//    - slot[sel_q]==0: go to SOLDOUT.
//    - otherwise: slot[sel_q] <= slot[sel_q]-1, clear the cycle counter and go to DISPENSE.
//    - A count never underflows.
//  - DISPENSE: Dispense=1 for exactly DISP_CYCLES cycles, then go to DONE.
//  - DONE: Done=1 for 1 cycle, then go to IDLE.
//  - SOLDOUT: SoldOut=1 for 1 cycle, then go to IDLE. No count changes.
//  - While Busy=1, Vend and Restock are ignored and are not queued. Changes on
//    S2..S0 while Busy do not affect the latched slot.
//  - Timing for Vend sampled at edge N:
//    - CHECK occupies cycle N+1.
//    - The decremented W is visible and Dispense=1 from N+2 through N+1+DISP_CYCLES.
//    - Done=1 at N+2+DISP_CYCLES, and the block is back in IDLE the following cycle.
//    - Sold-out path: SoldOut=1 at N+2, IDLE at N+3.
//  - Slots other than the latched or selected one never change except on Reset.
// TESTING
//  1 Reset, then read W0..W7 -> all =5; Dispense, Done, SoldOut and Busy =0.
//  2 sel=3, 1-cycle Vend at N -> Busy at N+1, W3=4 and Dispense=1 for N+2..N+5,
//    Done pulse at N+6, Busy=0 at N+7.
//  3 Vend slot 6 six times -> five Done pulses with W6 counting 4..0.
//    The sixth vend gives one SoldOut pulse, no Dispense, and W6 stays 0.
//  4 Restock slot 0 (count 5) with RestockVal=7 -> W0=12 next cycle.
//    Then RestockVal=9 -> W0=15 (saturated, no wrap).
//  5 Vend+Restock in the same IDLE cycle on slot 2 -> vend proceeds (W2=4) and the
//    restock is dropped. Vend on slot 1 pulsed while Busy -> ignored, W1 stays 5.
//  6 Change S to 7 during DISPENSE of slot 2 -> W7 unchanged.
//    Assert Reset during DISPENSE -> next cycle all W=5, Dispense=0, state IDLE.

Source files
------------

// File: rtl/item_count_bank.sv
// item_count_bank: eight saturating item counters with a vend/restock FSM that times the dispense pulse
module item_count_bank #(
  parameter int WIDTH       = 4,
  parameter int INIT_COUNT  = 5,
  parameter int MAX_COUNT   = 15,
  parameter int DISP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  input  logic             vend,
  input  logic             restock,
  input  logic [WIDTH-1:0] restock_val,
  output logic [WIDTH-1:0] w0,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] w3,
  output logic [WIDTH-1:0] w4,
  output logic [WIDTH-1:0] w5,
  output logic [WIDTH-1:0] w6,
  output logic [WIDTH-1:0] w7,
  output logic             dispense,
  output logic             done,
  output logic             sold_out,
  output logic             busy
);
  localparam int CW = $clog2(DISP_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DISP, S_DONE, S_SOLD} state_t;
  state_t           state;
  logic [WIDTH-1:0] slot [8];
  logic [2:0]       sel, sel_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  assign sel = {s2, s1, s0};
  // one extra bit so the restock sum can be clamped instead of wrapping
  assign sum = {1'b0, slot[sel]} + {1'b0, restock_val};
  assign {w0, w1, w2, w3} = {slot[0], slot[1], slot[2], slot[3]};
  assign {w4, w5, w6, w7} = {slot[4], slot[5], slot[6], slot[7]};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) slot[i] <= WIDTH'(INIT_COUNT);
      state    <= S_IDLE;
      sel_q    <= '0;
      cnt      <= '0;
      dispense <= 1'b0;
      done     <= 1'b0;
      sold_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (vend) begin
            sel_q <= sel;
            busy  <= 1'b1;
            state <= S_CHECK;
          end else if (restock) begin
            slot[sel] <= (sum > (WIDTH+1)'(MAX_COUNT)) ? WIDTH'(MAX_COUNT) : sum[WIDTH-1:0];
          end
        S_CHECK:
          if (slot[sel_q] == '0) begin
            sold_out <= 1'b1;
            state    <= S_SOLD;
          end else begin
            slot[sel_q] <= slot[sel_q] - 1'b1;
            cnt         <= '0;
            dispense    <= 1'b1;
            state       <= S_DISP;
          end
        S_DISP:
          if (cnt == CW'(DISP_CYCLES - 1)) begin
            dispense <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_SOLD: begin
          sold_out <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
